axil_cmd_master: RTL and testbench
==================================

Name: axil_cmd_master

Overview:
- Native AXI4-Lite initiator.
- Converts single-beat write/read commands from on-chip control logic (DAC sequencer, calibration FSM) into AXI-Lite transactions.
- Drives the same register slaves that the JTAG debug path reaches, so firmware-free logic can program them.
- One outstanding transaction at a time. Results return on a valid/ready response channel.

Parameters:
- ADDR_WIDTH, 32, AXI address width.
- DATA_WIDTH, 32, AXI data width. Must be 32 or 64.
- TIMEOUT_CYCLES, 1024, cycles allowed per transaction before abort. 0 disables the timeout.

Ports:
- aclk  in  1  clock
- arst  in  1  synchronous active-high reset
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command accepted
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  ADDR_WIDTH  byte address
- cmd_wdata  in  DATA_WIDTH  write data
- cmd_wstrb  in  DATA_WIDTH/8  write strobes
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed
- rsp_rdata  out  DATA_WIDTH  read data (0 for writes)
- rsp_resp  out  2  AXI BRESP/RRESP
- rsp_timeout  out  1  transaction aborted by timeout
- busy  out  1  state != IDLE
- m_axil_aw{addr,prot,valid}/awready, w{data,strb,valid}/wready, b{resp,valid}/bready, ar{addr,prot,valid}/arready, r{data,resp,valid}/rready: standard AXI4-Lite master signals, widths per parameters.

Behaviour:
- Clock and reset: one clock, aclk; reset is synchronous and active-high, arst.
- Reset values:
  - All AXI valid/ready outputs 0.
  - cmd_ready=0, rsp_valid=0, busy=0.
  - rsp_* data=0, addr/data outputs=0, state IDLE.
  - Reset mid-transaction aborts at the next edge with no response generated.
- States: IDLE, WR, WR_RESP, RD, RD_DATA, RSP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready: latch addr, data and strb, clear the timeout counter, go to WR or RD.
  - AXI valids rise on the cycle after acceptance (latency 1).
- Address and prot:
  - addr bits [log2(DATA_WIDTH/8)-1:0] are forced to 0.
  - awprot and arprot are always 3'b000.
- WR:
  - awvalid and wvalid assert together.
  - Each drops the cycle after its own handshake. Same-cycle awready and wready is legal.
  - The address/data handshake order is unconstrained.
  - Once both handshakes are done, go to WR_RESP.
- WR_RESP:
  - bready=1.
  - On bvalid, latch bresp, set rsp_rdata=0, go to RSP.
- RD:
  - arvalid held until arready, then go to RD_DATA.
- RD_DATA:
  - rready=1.
  - On rvalid, latch rdata and rresp, go to RSP.
- RSP:
  - rsp_valid=1; payload is stable while rsp_valid && !rsp_ready.
  - On rsp_ready, go to IDLE. cmd_ready reasserts the following cycle.
  - Minimum command-to-command spacing: 4 cycles for reads, 4 for writes.
- AXI stability: valid signals are never withdrawn before their handshake, except by timeout or reset. Payloads are stable while valid.
- Timeout:
  - Counter increments every cycle in WR, WR_RESP, RD or RD_DATA.
  - When it reaches TIMEOUT_CYCLES-1 without completing, the block deasserts all AXI valid/ready outputs and goes to RSP with rsp_timeout=1, rsp_resp=2'b10, rsp_rdata=0.
  - If the completion handshake (bvalid or rvalid) coincides with expiry, completion wins and rsp_timeout=0.
  - The abort is intended for absent or hung slaves only.
- rsp_timeout is cleared on the next command accept.
- cmd inputs are ignored outside IDLE.

Test Plan:
1. Write, immediate slave: cmd_write=1, addr=0x0000_0007, wdata=0xDEAD_BEEF, wstrb=0xF → awaddr=0x0000_0004, wdata=0xDEADBEEF; awvalid/wvalid high 1 cycle after accept; response rsp_resp=00, rsp_timeout=0, rsp_rdata=0.
2. Skewed write:
   - Stimulus: wready asserted 3 cycles before awready, then bvalid delayed 5 cycles, bresp=2'b10.
   - Response: wvalid drops after its handshake while awvalid stays high; bready is high only after both handshakes; rsp_resp=10.
3. Read:
   - Stimulus: addr=0x10; arready at cycle 2; rvalid at cycle 4 with rdata=0x1234_5678, rresp=00.
   - Response: rsp_rdata=0x12345678; rready=1 only in RD_DATA.
4. Backpressure: rsp_ready held low 10 cycles → rsp_valid stays 1 with a stable payload; cmd_ready=0 throughout; cmd_valid pulses are ignored.
5. Timeout:
   - Stimulus: TIMEOUT_CYCLES=16, slave never asserts arready.
   - Response: arvalid drops after 16 cycles in RD; rsp_timeout=1, rsp_resp=10, rsp_rdata=0.
   - Repeat with rvalid landing exactly on the expiry cycle → normal response, rsp_timeout=0.
6. Reset mid-write: arst=1 while awvalid=1 → next edge: all valids 0, busy=0, no rsp_valid. After release, cmd_ready=1 and a new write completes normally.

Source files
------------

// File: rtl/axil_cmd_master.sv
// Single-outstanding AXI4-Lite initiator: turns one write/read command into one AXI-Lite transaction and one response.
// AXI valids rise the cycle after command accept; the response is held until rsp_ready and no new command is taken meanwhile.
module axil_cmd_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    aclk,
    input  logic                    arst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]              rsp_resp,
    output logic                    rsp_timeout,
    output logic                    busy,
    output logic [ADDR_WIDTH-1:0]   m_axil_awaddr,
    output logic [2:0]              m_axil_awprot,
    output logic                    m_axil_awvalid,
    input  logic                    m_axil_awready,
    output logic [DATA_WIDTH-1:0]   m_axil_wdata,
    output logic [DATA_WIDTH/8-1:0] m_axil_wstrb,
    output logic                    m_axil_wvalid,
    input  logic                    m_axil_wready,
    input  logic [1:0]              m_axil_bresp,
    input  logic                    m_axil_bvalid,
    output logic                    m_axil_bready,
    output logic [ADDR_WIDTH-1:0]   m_axil_araddr,
    output logic [2:0]              m_axil_arprot,
    output logic                    m_axil_arvalid,
    input  logic                    m_axil_arready,
    input  logic [DATA_WIDTH-1:0]   m_axil_rdata,
    input  logic [1:0]              m_axil_rresp,
    input  logic                    m_axil_rvalid,
    output logic                    m_axil_rready
);

    localparam int LSB = $clog2(DATA_WIDTH / 8);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~ADDR_WIDTH'((64'd1 << LSB) - 64'd1);
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam bit TO_EN = (TIMEOUT_CYCLES > 0);

    typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD, RD_DATA, RSP} state_t;

    state_t                  state, next_state;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH/8-1:0] wstrb_q;
    logic                    aw_done, w_done;
    logic [CNT_W-1:0]        cnt;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic [1:0]              resp_q;
    logic                    timeout_q;
    logic                    aw_hs, w_hs, done, axi_active, expire;

    always_comb begin
        next_state = state;
        aw_hs      = m_axil_awvalid && m_axil_awready;
        w_hs       = m_axil_wvalid && m_axil_wready;
        done       = (state == WR_RESP && m_axil_bvalid) || (state == RD_DATA && m_axil_rvalid);
        axi_active = (state == WR) || (state == WR_RESP) || (state == RD) || (state == RD_DATA);
        // A completion landing on the last allowed cycle beats the abort.
        expire     = axi_active && TO_EN && (cnt == CNT_LAST) && !done;
        case (state)
            IDLE:    if (cmd_valid && cmd_ready) next_state = cmd_write ? WR : RD;
            WR: begin
                if (expire)
                    next_state = RSP;
                else if ((aw_done || aw_hs) && (w_done || w_hs))
                    next_state = WR_RESP;
            end
            WR_RESP: if (done || expire) next_state = RSP;
            RD: begin
                if (expire)
                    next_state = RSP;
                else if (m_axil_arready)
                    next_state = RD_DATA;
            end
            RD_DATA: if (done || expire) next_state = RSP;
            RSP:     if (rsp_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (arst) begin
            state     <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            cnt       <= '0;
            rdata_q   <= '0;
            resp_q    <= 2'b00;
            timeout_q <= 1'b0;
        end else begin
            state <= next_state;
            if (axi_active)
                cnt <= cnt + CNT_W'(1);
            if (state == IDLE && cmd_valid) begin
                addr_q    <= cmd_addr & ADDR_MASK;
                wdata_q   <= cmd_wdata;
                wstrb_q   <= cmd_wstrb;
                aw_done   <= 1'b0;
                w_done    <= 1'b0;
                cnt       <= '0;
                timeout_q <= 1'b0;
            end
            if (state == WR) begin
                aw_done <= aw_done || aw_hs;
                w_done  <= w_done || w_hs;
            end
            if (state == WR_RESP && m_axil_bvalid) begin
                resp_q  <= m_axil_bresp;
                rdata_q <= '0;
            end
            if (state == RD_DATA && m_axil_rvalid) begin
                resp_q  <= m_axil_rresp;
                rdata_q <= m_axil_rdata;
            end
            if (expire) begin
                timeout_q <= 1'b1;
                resp_q    <= 2'b10;
                rdata_q   <= '0;
            end
        end
    end

    assign cmd_ready      = (state == IDLE) && !arst;
    assign busy           = (state != IDLE);
    assign rsp_valid      = (state == RSP);
    assign rsp_rdata      = rdata_q;
    assign rsp_resp       = resp_q;
    assign rsp_timeout    = timeout_q;
    assign m_axil_awaddr  = addr_q;
    assign m_axil_awprot  = 3'b000;
    assign m_axil_awvalid = (state == WR) && !aw_done;
    assign m_axil_wdata   = wdata_q;
    assign m_axil_wstrb   = wstrb_q;
    assign m_axil_wvalid  = (state == WR) && !w_done;
    assign m_axil_bready  = (state == WR_RESP);
    assign m_axil_araddr  = addr_q;
    assign m_axil_arprot  = 3'b000;
    assign m_axil_arvalid = (state == RD);
    assign m_axil_rready  = (state == RD_DATA);

endmodule

// File: tb/tb_axil_cmd_master.sv
// Scoreboard bench for axil_cmd_master: scripted AXI-Lite slave responses, expected responses queued at command time.
module tb_axil_cmd_master;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    logic          aclk = 1'b0;
    logic          arst;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [3:0]    cmd_wstrb;
    logic          rsp_valid, rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_resp;
    logic          rsp_timeout, busy;
    logic [AW-1:0] awaddr, araddr;
    logic [2:0]    awprot, arprot;
    logic          awvalid, awready, wvalid, wready, bvalid, bready;
    logic [DW-1:0] wdata, rdata;
    logic [3:0]    wstrb;
    logic [1:0]    bresp, rresp;
    logic          arvalid, arready, rvalid, rready;

    axil_cmd_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .aclk(aclk), .arst(arst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout), .busy(busy),
        .m_axil_awaddr(awaddr), .m_axil_awprot(awprot), .m_axil_awvalid(awvalid), .m_axil_awready(awready),
        .m_axil_wdata(wdata), .m_axil_wstrb(wstrb), .m_axil_wvalid(wvalid), .m_axil_wready(wready),
        .m_axil_bresp(bresp), .m_axil_bvalid(bvalid), .m_axil_bready(bready),
        .m_axil_araddr(araddr), .m_axil_arprot(arprot), .m_axil_arvalid(arvalid), .m_axil_arready(arready),
        .m_axil_rdata(rdata), .m_axil_rresp(rresp), .m_axil_rvalid(rvalid), .m_axil_rready(rready)
    );

    always #5 aclk = ~aclk;

    typedef struct packed {
        logic [31:0] rdata;
        logic [1:0]  resp;
        logic        to;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic idle_inputs();
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
        rsp_ready = 1'b0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00;
    endtask

    task automatic wait_rsp(input int max_cycles, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            if (rsp_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        arst = 1'b1;
        idle_inputs();
        tick(); tick();
        n_cmp++;
        if ({cmd_ready, busy, rsp_valid, awvalid, wvalid, bready, arvalid, rready} !== 8'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b, want 00000000",
                     {cmd_ready, busy, rsp_valid, awvalid, wvalid, bready, arvalid, rready});
        end
        n_cmp++;
        if ({awaddr, araddr, wdata, wstrb, rsp_rdata, rsp_resp, rsp_timeout, awprot, arprot} !== '0) begin
            n_err++;
            $display("FAIL reset_data: awaddr=%h araddr=%h wdata=%h rsp_rdata=%h resp=%b to=%b, want all 0",
                     awaddr, araddr, wdata, rsp_rdata, rsp_resp, rsp_timeout);
        end
        arst = 1'b0;
        tick();
        n_cmp++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: cmd_ready=%b busy=%b, want 1 0", cmd_ready, busy);
        end
    endtask

    task automatic test_write_immediate();
        exp_t e;
        bit   ok;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0000_0007;
        cmd_wdata = 32'hDEAD_BEEF; cmd_wstrb = 4'hF;
        awready = 1'b1; wready = 1'b1;
        sb.push_back('{rdata: 32'h0, resp: 2'b00, to: 1'b0});
        tick();
        cmd_valid = 1'b0;
        n_cmp++;
        if ({awvalid, wvalid, cmd_ready, bready} !== 4'b1100 || awaddr !== 32'h4 ||
            wdata !== 32'hDEADBEEF || wstrb !== 4'hF || awprot !== 3'b000) begin
            n_err++;
            $display("FAIL wr_issue: aw/w/cmd_rdy/bready=%b awaddr=%h wdata=%h wstrb=%h, want 1100 00000004 deadbeef f",
                     {awvalid, wvalid, cmd_ready, bready}, awaddr, wdata, wstrb);
        end
        tick();
        awready = 1'b0; wready = 1'b0;
        n_cmp++;
        if ({awvalid, wvalid, bready} !== 3'b001) begin
            n_err++;
            $display("FAIL wr_resp_wait: aw/w/bready=%b, want 001", {awvalid, wvalid, bready});
        end
        bvalid = 1'b1; bresp = 2'b00;
        tick();
        bvalid = 1'b0;
        wait_rsp(20, ok);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL wr_rsp_valid: rsp_valid=%b after 20 cycles, want 1", rsp_valid);
        end
        e = sb.pop_front();
        n_cmp++;
        if ({rsp_rdata, rsp_resp, rsp_timeout} !== {e.rdata, e.resp, e.to}) begin
            n_err++;
            $display("FAIL wr_rsp: rdata=%h resp=%b to=%b, want rdata=%h resp=%b to=%b",
                     rsp_rdata, rsp_resp, rsp_timeout, e.rdata, e.resp, e.to);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        n_cmp++;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL wr_cmd_rearm: cmd_ready=%b rsp_valid=%b, want 1 0", cmd_ready, rsp_valid);
        end
    endtask

    task automatic test_skewed_write();
        exp_t e;
        bit   ok;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h20;
        cmd_wdata = 32'h1122_3344; cmd_wstrb = 4'h3;
        sb.push_back('{rdata: 32'h0, resp: 2'b10, to: 1'b0});
        tick();
        cmd_valid = 1'b0;
        wready = 1'b1;
        tick();
        wready = 1'b0;
        for (int c = 2; c <= 4; c++) begin
            n_cmp++;
            if ({awvalid, wvalid, bready} !== 3'b100) begin
                n_err++;
                $display("FAIL skew_aw_only c%0d: aw/w/bready=%b, want 100", c, {awvalid, wvalid, bready});
            end
            if (c == 4) awready = 1'b1;
            tick();
        end
        awready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            n_cmp++;
            if ({awvalid, bready, rsp_valid} !== 3'b010) begin
                n_err++;
                $display("FAIL skew_bwait c%0d: aw/bready/rsp_valid=%b, want 010", c, {awvalid, bready, rsp_valid});
            end
            tick();
        end
        bvalid = 1'b1; bresp = 2'b10;
        tick();
        bvalid = 1'b0; bresp = 2'b00;
        wait_rsp(20, ok);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL skew_rsp_valid: rsp_valid=%b after 20 cycles, want 1", rsp_valid);
        end
        e = sb.pop_front();
        n_cmp++;
        if ({rsp_rdata, rsp_resp, rsp_timeout} !== {e.rdata, e.resp, e.to}) begin
            n_err++;
            $display("FAIL skew_rsp: rdata=%h resp=%b to=%b, want rdata=%h resp=%b to=%b",
                     rsp_rdata, rsp_resp, rsp_timeout, e.rdata, e.resp, e.to);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_read();
        exp_t e;
        bit   ok;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h10;
        sb.push_back('{rdata: 32'h1234_5678, resp: 2'b00, to: 1'b0});
        tick();
        cmd_valid = 1'b0;
        n_cmp++;
        if ({arvalid, rready, awvalid} !== 3'b100 || araddr !== 32'h10 || arprot !== 3'b000) begin
            n_err++;
            $display("FAIL rd_issue: ar/rready/aw=%b araddr=%h, want 100 00000010", {arvalid, rready, awvalid}, araddr);
        end
        tick();
        arready = 1'b1;
        n_cmp++;
        if ({arvalid, rready} !== 2'b10) begin
            n_err++;
            $display("FAIL rd_ar_hold: ar/rready=%b, want 10", {arvalid, rready});
        end
        tick();
        arready = 1'b0;
        n_cmp++;
        if ({arvalid, rready} !== 2'b01) begin
            n_err++;
            $display("FAIL rd_data_wait: ar/rready=%b, want 01", {arvalid, rready});
        end
        tick();
        rvalid = 1'b1; rdata = 32'h1234_5678; rresp = 2'b00;
        tick();
        rvalid = 1'b0; rdata = '0;
        n_cmp++;
        if (rready !== 1'b0) begin
            n_err++;
            $display("FAIL rd_rready_drop: rready=%b, want 0", rready);
        end
        wait_rsp(20, ok);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL rd_rsp_valid: rsp_valid=%b after 20 cycles, want 1", rsp_valid);
        end
        e = sb.pop_front();
        n_cmp++;
        if ({rsp_rdata, rsp_resp, rsp_timeout} !== {e.rdata, e.resp, e.to}) begin
            n_err++;
            $display("FAIL rd_rsp: rdata=%h resp=%b to=%b, want rdata=%h resp=%b to=%b",
                     rsp_rdata, rsp_resp, rsp_timeout, e.rdata, e.resp, e.to);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        exp_t e;
        bit   ok;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h44;
        arready = 1'b1;
        sb.push_back('{rdata: 32'hCAFE_F00D, resp: 2'b01, to: 1'b0});
        tick();
        cmd_valid = 1'b0;
        tick();
        arready = 1'b0;
        rvalid = 1'b1; rdata = 32'hCAFE_F00D; rresp = 2'b01;
        tick();
        rvalid = 1'b0; rdata = 32'h5555_AAAA; rresp = 2'b11;
        wait_rsp(20, ok);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL bp_rsp_valid: rsp_valid=%b after 20 cycles, want 1", rsp_valid);
        end
        e = sb.pop_front();
        for (int c = 0; c < 10; c++) begin
            cmd_valid = c[0]; cmd_write = 1'b1; cmd_addr = 32'h100 + 32'(c);
            n_cmp++;
            if (rsp_valid !== 1'b1 || cmd_ready !== 1'b0 ||
                {rsp_rdata, rsp_resp, rsp_timeout} !== {e.rdata, e.resp, e.to}) begin
                n_err++;
                $display("FAIL bp_hold c%0d: valid=%b cmd_ready=%b rdata=%h resp=%b to=%b, want 1 0 %h %b %b",
                         c, rsp_valid, cmd_ready, rsp_rdata, rsp_resp, rsp_timeout, e.rdata, e.resp, e.to);
            end
            tick();
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        n_cmp++;
        if ({rsp_valid, busy, awvalid, arvalid, cmd_ready} !== 5'b00001) begin
            n_err++;
            $display("FAIL bp_release: valid/busy/aw/ar/cmd_ready=%b, want 00001",
                     {rsp_valid, busy, awvalid, arvalid, cmd_ready});
        end
    endtask

    task automatic test_timeout();
        exp_t e;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h80;
        sb.push_back('{rdata: 32'h0, resp: 2'b10, to: 1'b1});
        tick();
        cmd_valid = 1'b0;
        for (int c = 1; c <= TO; c++) begin
            n_cmp++;
            if (arvalid !== 1'b1 || rsp_valid !== 1'b0) begin
                n_err++;
                $display("FAIL to_ar_hold c%0d: arvalid=%b rsp_valid=%b, want 1 0", c, arvalid, rsp_valid);
            end
            tick();
        end
        n_cmp++;
        if ({arvalid, rready, rsp_valid} !== 3'b001) begin
            n_err++;
            $display("FAIL to_abort: ar/rready/rsp_valid=%b, want 001", {arvalid, rready, rsp_valid});
        end
        e = sb.pop_front();
        n_cmp++;
        if ({rsp_rdata, rsp_resp, rsp_timeout} !== {e.rdata, e.resp, e.to}) begin
            n_err++;
            $display("FAIL to_rsp: rdata=%h resp=%b to=%b, want rdata=%h resp=%b to=%b",
                     rsp_rdata, rsp_resp, rsp_timeout, e.rdata, e.resp, e.to);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_timeout_race();
        exp_t e;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h84;
        sb.push_back('{rdata: 32'h5A5A_1234, resp: 2'b00, to: 1'b0});
        tick();
        cmd_valid = 1'b0;
        arready = 1'b1;
        tick();
        arready = 1'b0;
        for (int c = 2; c < TO; c++) begin
            n_cmp++;
            if ({rready, rsp_valid} !== 2'b10) begin
                n_err++;
                $display("FAIL race_wait c%0d: rready/rsp_valid=%b, want 10", c, {rready, rsp_valid});
            end
            tick();
        end
        rvalid = 1'b1; rdata = 32'h5A5A_1234; rresp = 2'b00;
        n_cmp++;
        if (rready !== 1'b1) begin
            n_err++;
            $display("FAIL race_last_cycle: rready=%b, want 1", rready);
        end
        tick();
        rvalid = 1'b0; rdata = '0;
        e = sb.pop_front();
        n_cmp++;
        if (rsp_valid !== 1'b1 || {rsp_rdata, rsp_resp, rsp_timeout} !== {e.rdata, e.resp, e.to}) begin
            n_err++;
            $display("FAIL race_rsp: valid=%b rdata=%h resp=%b to=%b, want 1 %h %b %b",
                     rsp_valid, rsp_rdata, rsp_resp, rsp_timeout, e.rdata, e.resp, e.to);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid_write();
        exp_t e;
        bit   ok;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h30; cmd_wdata = 32'h0BAD_0BAD; cmd_wstrb = 4'hF;
        tick();
        cmd_valid = 1'b0;
        n_cmp++;
        if (awvalid !== 1'b1) begin
            n_err++;
            $display("FAIL rstmid_pre: awvalid=%b, want 1", awvalid);
        end
        arst = 1'b1;
        tick();
        n_cmp++;
        if ({awvalid, wvalid, bready, busy, rsp_valid, cmd_ready} !== 6'b0) begin
            n_err++;
            $display("FAIL rstmid_abort: aw/w/b/busy/rsp_valid/cmd_ready=%b, want 000000",
                     {awvalid, wvalid, bready, busy, rsp_valid, cmd_ready});
        end
        arst = 1'b0;
        tick();
        n_cmp++;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid_release: cmd_ready=%b rsp_valid=%b, want 1 0", cmd_ready, rsp_valid);
        end
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h3E; cmd_wdata = 32'h0102_0304; cmd_wstrb = 4'hC;
        awready = 1'b1; wready = 1'b1;
        sb.push_back('{rdata: 32'h0, resp: 2'b00, to: 1'b0});
        tick();
        cmd_valid = 1'b0;
        n_cmp++;
        if (awaddr !== 32'h3C || wdata !== 32'h01020304 || wstrb !== 4'hC) begin
            n_err++;
            $display("FAIL rstmid_wr_payload: awaddr=%h wdata=%h wstrb=%h, want 0000003c 01020304 c",
                     awaddr, wdata, wstrb);
        end
        tick();
        awready = 1'b0; wready = 1'b0;
        bvalid = 1'b1;
        tick();
        bvalid = 1'b0;
        wait_rsp(20, ok);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL rstmid_rsp_valid: rsp_valid=%b after 20 cycles, want 1", rsp_valid);
        end
        e = sb.pop_front();
        n_cmp++;
        if ({rsp_rdata, rsp_resp, rsp_timeout} !== {e.rdata, e.resp, e.to}) begin
            n_err++;
            $display("FAIL rstmid_rsp: rdata=%h resp=%b to=%b, want rdata=%h resp=%b to=%b",
                     rsp_rdata, rsp_resp, rsp_timeout, e.rdata, e.resp, e.to);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_write_immediate();
        test_skewed_write();
        test_read();
        test_backpressure();
        test_timeout();
        test_timeout_race();
        test_reset_mid_write();
        n_cmp++;
        if (sb.size() !== 0) begin
            n_err++;
            $display("FAIL sb_drain: %0d expected responses left, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded 200000 time units");
        $fatal(1, "watchdog");
    end

endmodule
